// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: RV32I format codes, opcodes, NOP and field encode/check helpers shared with decode
package riscv_enc_pkg;
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;
  typedef struct packed {
    logic [2:0] fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
  } fields_t;
  function automatic logic [31:0] encode(input fields_t f);
    return f.fmt == FMT_R ? {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode} :
           f.fmt == FMT_I ? {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode} :
           f.fmt == FMT_S ? {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode} :
           f.fmt == FMT_B ? {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11], f.opcode} :
           f.fmt == FMT_U ? {f.imm[31:12], f.rd, f.opcode} :
           f.fmt == FMT_J ? {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode} :
           NOP;
  endfunction
  function automatic logic bad_imm(input fields_t f);
    logic signed [31:0] s;
    s = $signed(f.imm);
    return (f.fmt == FMT_I || f.fmt == FMT_S) ? (s < -32'sd2048 || s > 32'sd2047) :
           f.fmt == FMT_B ? (f.imm[0] || s < -32'sd4096 || s > 32'sd4094) :
           f.fmt == FMT_J ? (f.imm[0] || s < -32'sd1048576 || s > 32'sd1048574) :
           f.fmt == FMT_U ? (f.imm[11:0] != 12'd0) :
           f.fmt != FMT_R;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous DEPTH x W FIFO with flush, full/empty and occupancy count
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    rdata = empty ? '0 : mem[rp];
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I field packer streaming words to imem; INSTR_ENCODER_CHECK_EN adds sticky err
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  fields_t f;
  logic full, empty, push, pop;
  always_comb begin
    f = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
          rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    in_ready = !full && !start;
    push = in_valid && in_ready;
    out_valid = !empty;
    pop = out_valid && out_ready;
  end
  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst(rst), .flush(start), .push(push), .pop(pop),
    .wdata(encode(f)), .rdata(out_instr), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (rst) out_addr <= '0;
    else if (start) out_addr <= base_addr;
    else if (pop) out_addr <= out_addr + ADDR_W'(4);
`ifdef INSTR_ENCODER_CHECK_EN
  always_ff @(posedge clk)
    if (rst || start) err <= 1'b0;
    else if (push && bad_imm(f)) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder (word, address, flow control, start, reset, err)
module tb_instr_encoder;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [31:0] base_addr = 0, in_imm = 0;
  logic [2:0] in_fmt = 0, in_funct3 = 0;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [2:0] count;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr = 0;

  instr_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got instr=%h addr=%h, scoreboard empty", out_instr, out_addr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({out_instr, out_addr} !== e) begin
          n_bad++;
          $display("FAIL word: got instr=%h addr=%h, want instr=%h addr=%h", out_instr, out_addr, e[63:32], e[31:0]);
        end
      end
    end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
    int t = 0;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL accept: in_ready=%b after %0d cycles, want 1", in_ready, t);
    end else begin
      sb.push_back({exp, exp_addr});
      exp_addr += 4;
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1; base_addr = b;
    @(posedge clk);
    #1 start = 0; base_addr = 32'hDEAD_BEEF;
    sb.delete();
    exp_addr = b;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      t++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain: %0d words outstanding, out_valid=%b, want 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, count, out_addr, out_instr, err, in_ready} !== {1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: got v=%b cnt=%0d addr=%h instr=%h err=%b rdy=%b, want 0 0 0 0 0 1",
               out_valid, count, out_addr, out_instr, err, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_r();
    do_start(32'h100);
    out_ready = 1;
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'h0020_81B3);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0, 32'h4020_81B3);
    drain();
  endtask

  task automatic test_stream();
    do_start(32'h100);
    out_ready = 1;
    send(3'd1, 7'h13, 3'd0, 7'h7F, 5'd5, 5'd0, 5'd31, 32'hFFFF_FFFF, 32'hFFF0_0293);
    n_cmp++;
    if (!out_valid || out_addr !== 32'h100 || out_instr !== 32'hFFF0_0293) begin
      n_bad++;
      $display("FAIL stream_first: v=%b addr=%h instr=%h, want 1 00000100 fff00293", out_valid, out_addr, out_instr);
    end
    send(3'd2, 7'h23, 3'd2, 7'h7F, 5'd31, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
    n_cmp++;
    if (!out_valid || out_addr !== 32'h104 || out_instr !== 32'h0020_A423) begin
      n_bad++;
      $display("FAIL stream_next: v=%b addr=%h instr=%h, want 1 00000104 0020a423", out_valid, out_addr, out_instr);
    end
    drain();
  endtask

  task automatic test_b_u_j_illegal();
    out_ready = 1;
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF);
    send(3'd7, 7'h33, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h1234_5678, 32'h0000_0013);
    send(3'd6, 7'h33, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h1234_5678, 32'h0000_0013);
    drain();
    n_cmp++;
`ifdef INSTR_ENCODER_CHECK_EN
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_illegal: err=%b, want 1", err);
    end
`else
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_off: err=%b, want 0", err);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_start(32'h300);
    out_ready = 0;
    for (int i = 0; i < 4; i++)
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i), {12'(i), 20'h00093});
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full: count=%0d in_ready=%b, want 4 0", count, in_ready);
    end
    @(posedge clk);
    #1;
    fork
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4, 32'h0040_0093);
      begin
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || sb.size() != 4) begin
          n_bad++;
          $display("FAIL refuse: in_ready=%b queued=%0d, want 0 4", in_ready, sb.size());
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_start_flush();
    do_start(32'h500);
    out_ready = 0;
    for (int i = 0; i < 3; i++)
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, {20'(i + 1), 12'h0}, {20'(i + 1), 12'h137});
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL preflush: count=%0d, want 3", count);
    end
    @(posedge clk);
    #1 start = 1; base_addr = 32'h2000; in_valid = 1;
    in_fmt = 3'd0; in_opcode = 7'h33; in_rd = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ready: in_ready=%b, want 0", in_ready);
    end
    @(posedge clk);
    #1 start = 0; in_valid = 0; base_addr = 32'hDEAD_BEEF;
    sb.delete();
    exp_addr = 32'h2000;
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'h2000) begin
      n_bad++;
      $display("FAIL flush: count=%0d v=%b addr=%h, want 0 0 00002000", count, out_valid, out_addr);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0020_81B3);
    drain();
  endtask

  task automatic test_rst_mid();
    do_start(32'h800);
    out_ready = 0;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    exp_addr = 0;
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'd0 || out_instr !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid: count=%0d v=%b addr=%h instr=%h, want 0 0 0 0", count, out_valid, out_addr, out_instr);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 32'h0030_0093);
    drain();
  endtask

`ifdef INSTR_ENCODER_CHECK_EN
  task automatic test_check();
    do_start(32'h0);
    out_ready = 1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear0: err=%b, want 0", err);
    end
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0293);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4094, 32'h7E20_8FE3);
    drain();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_inrange: err=%b, want 0", err);
    end
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd4096, 32'h0000_0293);
    drain();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: err=%b, want 1", err);
    end
    do_start(32'h40);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_r();
    test_stream();
    test_b_u_j_illegal();
    test_backpressure();
    test_start_flush();
    test_rst_mid();
`ifdef INSTR_ENCODER_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
